// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns single-cycle LSU stores into HD44780 write cycles on the
// DE2 character LCD. Requests are buffered in a small FIFO. A full FIFO drops
// the request and sets the sticky overflow flag.
// Optional macro LCD_INIT_EN: runs a power-up wait and the standard init
// sequence (0x38, 0x0C, 0x01, 0x06) before the FIFO is serviced.
module lcd_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned EN_HIGH_CYC = 12,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned EXEC_CYC    = 2000,
  parameter int unsigned CLR_CYC     = 82000,
  parameter int unsigned PWRUP_CYC   = 750000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic       i_wr_rs,
  input  logic [7:0] i_wr_data,
  input  logic       i_lcd_on,
  input  logic       i_ovf_clr,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_busy,
  output logic       o_ovf,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned MAX_A = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
  localparam int unsigned MAX_B = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int unsigned MAX_C = (MAX_B > EXEC_CYC) ? MAX_B : EXEC_CYC;
  localparam int unsigned MAX_D = (MAX_C > CLR_CYC) ? MAX_C : CLR_CYC;
  localparam int unsigned MAX_E = (MAX_D > PWRUP_CYC) ? MAX_D : PWRUP_CYC;
  localparam int unsigned CW    = $clog2(MAX_E) + 1;

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] CLR_LD   = CW'(CLR_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_EN_HI = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
`ifdef LCD_INIT_EN
  localparam logic [2:0] S_INIT_WAIT = 3'd5;
  localparam logic [2:0] S_INIT_SEQ  = 3'd6;
  localparam logic [2:0] S_RESET     = S_INIT_WAIT;
  localparam logic [CW-1:0] PWRUP_LD = CW'(PWRUP_CYC - 1);
`else
  localparam logic [2:0] S_RESET     = S_IDLE;
`endif

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [8:0]    head;
  logic          push;
  logic          pop;
  logic          is_clr;

  assign o_empty  = (wr_ptr == rd_ptr);
  assign o_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_busy   = (state != S_IDLE) || !o_empty;
  assign o_lcd_rw = 1'b0;

  // Push/pop qualification and clear/home detection for the long busy wait
  always_comb begin
    push   = i_wr_en && !o_full;
    pop    = (state == S_IDLE) && !o_empty;
    head   = mem[rd_ptr[AW-1:0]];
    is_clr = !o_lcd_rs && ((o_lcd_data == 8'h01) || (o_lcd_data == 8'h02) ||
                           (o_lcd_data == 8'h03));
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {i_wr_rs, i_wr_data};
  end

  // FIFO pointers with wrap bit
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                 o_ovf <= 1'b0;
    else if (i_wr_en && o_full) o_ovf <= 1'b1;
    else if (i_ovf_clr)         o_ovf <= 1'b0;
  end

  // Backlight/power request, registered once
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) o_lcd_on <= 1'b0;
    else        o_lcd_on <= i_lcd_on;
  end

`ifdef LCD_INIT_EN
  logic [2:0] init_idx;
  logic [7:0] init_cmd;

  // Init command table
  always_comb begin
    init_cmd = 8'h38;
    case (init_idx[1:0])
      2'd0: init_cmd = 8'h38;
      2'd1: init_cmd = 8'h0C;
      2'd2: init_cmd = 8'h01;
      2'd3: init_cmd = 8'h06;
      default: init_cmd = 8'h38;
    endcase
  end
`endif

  // Write-cycle sequencer: setup, EN pulse, hold, then execution wait
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= S_RESET;
      cnt        <= '0;
      o_lcd_en   <= 1'b0;
      o_lcd_rs   <= 1'b0;
      o_lcd_data <= '0;
`ifdef LCD_INIT_EN
      init_idx   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            o_lcd_rs   <= head[8];
            o_lcd_data <= head[7:0];
            cnt        <= SETUP_LD;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            o_lcd_en <= 1'b1;
            cnt      <= EN_LD;
            state    <= S_EN_HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_EN_HI: begin
          if (cnt == '0) begin
            o_lcd_en <= 1'b0;
            cnt      <= HOLD_LD;
            state    <= S_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            cnt   <= is_clr ? CLR_LD : EXEC_LD;
            state <= S_EXEC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
`ifdef LCD_INIT_EN
            // Init commands share the normal write path; loop back until all four are out
            state <= (init_idx != 3'd4) ? S_INIT_SEQ : S_IDLE;
`else
            state <= S_IDLE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef LCD_INIT_EN
        S_INIT_WAIT: begin
          if (cnt == PWRUP_LD) begin
            cnt   <= '0;
            state <= S_INIT_SEQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_INIT_SEQ: begin
          o_lcd_rs   <= 1'b0;
          o_lcd_data <= init_cmd;
          init_idx   <= init_idx + 1'b1;
          cnt        <= SETUP_LD;
          state      <= S_SETUP;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: scoreboard bench for lcd_ctrl. Stimulus queues the expected
// LCD writes; a monitor pops them on each EN rising edge and checks data,
// EN pulse width and the execution wait that follows.
module tb_lcd_ctrl;

  localparam int SETUP   = 2;
  localparam int EN_HIGH = 3;
  localparam int HOLD    = 1;
  localparam int EXEC    = 10;
  localparam int CLR     = 40;
  localparam int DEPTH   = 4;

  logic       i_clk;
  logic       i_rst;
  logic       i_wr_en;
  logic       i_wr_rs;
  logic [7:0] i_wr_data;
  logic       i_lcd_on;
  logic       i_ovf_clr;
  logic       o_full;
  logic       o_empty;
  logic       o_busy;
  logic       o_ovf;
  logic [7:0] o_lcd_data;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic       o_lcd_en;
  logic       o_lcd_on;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         exec;
  } item_t;

  item_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  lcd_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .SETUP_CYC  (SETUP),
    .EN_HIGH_CYC(EN_HIGH),
    .HOLD_CYC   (HOLD),
    .EXEC_CYC   (EXEC),
    .CLR_CYC    (CLR),
    .PWRUP_CYC  (100)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_wr_en),
    .i_wr_rs   (i_wr_rs),
    .i_wr_data (i_wr_data),
    .i_lcd_on  (i_lcd_on),
    .i_ovf_clr (i_ovf_clr),
    .o_full    (o_full),
    .o_empty   (o_empty),
    .o_busy    (o_busy),
    .o_ovf     (o_ovf),
    .o_lcd_data(o_lcd_data),
    .o_lcd_rs  (o_lcd_rs),
    .o_lcd_rw  (o_lcd_rw),
    .o_lcd_en  (o_lcd_en),
    .o_lcd_on  (o_lcd_on)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Drive one push for a cycle; returns at the negedge after the capturing edge
  task automatic push(input logic rs, input logic [7:0] d, input int exec, input bit accepted);
    item_t it;
    i_wr_en   = 1'b1;
    i_wr_rs   = rs;
    i_wr_data = d;
    if (accepted) begin
      it.rs = rs; it.d = d; it.exec = exec;
      sb.push_back(it);
    end
    @(negedge i_clk);
    i_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && o_busy; i++) @(negedge i_clk);
    check("idle_within_budget", int'(o_busy), 0);
    repeat (2) @(negedge i_clk);
  endtask

  // Monitor: pops the scoreboard on each EN rise and times the pulse and wait
  initial begin : monitor
    logic  prev_en;
    bit    in_gap;
    int    hi_cnt;
    int    gap_cnt;
    item_t cur;
    prev_en = 1'b0; in_gap = 0; hi_cnt = 0; gap_cnt = 0;
    cur.rs = 1'b0; cur.d = '0; cur.exec = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        prev_en = 1'b0; in_gap = 0; hi_cnt = 0;
      end else begin
        check("lcd_rw", int'(o_lcd_rw), 0);
        if (in_gap) begin
          gap_cnt++;
          if (o_lcd_en) begin
            check("exec_len_b2b", gap_cnt - HOLD - 2 - SETUP, cur.exec);
            in_gap = 0;
          end else if (!o_busy) begin
            check("exec_len", gap_cnt - HOLD - 1, cur.exec);
            in_gap = 0;
          end
        end
        if (o_lcd_en && !prev_en) begin
          check("write_expected", int'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            cur = sb.pop_front();
            check("lcd_data", int'(o_lcd_data), int'(cur.d));
            check("lcd_rs", int'(o_lcd_rs), int'(cur.rs));
          end
          hi_cnt = 1;
        end else if (o_lcd_en) begin
          hi_cnt++;
        end else if (prev_en) begin
          check("en_high_len", hi_cnt, EN_HIGH);
          in_gap  = 1;
          gap_cnt = 1;
        end
        prev_en = o_lcd_en;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    i_rst = 1'b0; i_wr_en = 1'b0; i_wr_rs = 1'b0; i_wr_data = '0;
    i_lcd_on = 1'b0; i_ovf_clr = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_data",  int'(o_lcd_data), 0);
    check("rst_rs",    int'(o_lcd_rs), 0);
    check("rst_rw",    int'(o_lcd_rw), 0);
    check("rst_en",    int'(o_lcd_en), 0);
    check("rst_on",    int'(o_lcd_on), 0);
    check("rst_full",  int'(o_full), 0);
    check("rst_empty", int'(o_empty), 1);
    check("rst_busy",  int'(o_busy), 0);
    check("rst_ovf",   int'(o_ovf), 0);
    i_rst = 1'b1;
    @(negedge i_clk);

    // Backlight request: one-cycle latency
    i_lcd_on = 1'b1;
    #1 check("lcd_on_before_edge", int'(o_lcd_on), 0);
    @(negedge i_clk);
    check("lcd_on_after_edge", int'(o_lcd_on), 1);

    // Single data write: cycle-exact latency from the push edge T
    @(negedge i_clk);
    push(1'b1, 8'h41, EXEC, 1);
    check("data_k0", int'(o_lcd_data), 0);
    for (int k = 1; k <= 18; k++) begin
      @(negedge i_clk);
      if (k == 1) begin
        check("data_k1", int'(o_lcd_data), 8'h41);
        check("rs_k1", int'(o_lcd_rs), 1);
      end
      check("en_timing", int'(o_lcd_en), (k >= 3 && k <= 5) ? 1 : 0);
      if (k == 16) check("busy_k16", int'(o_busy), 1);
      if (k == 17) check("busy_k17", int'(o_busy), 0);
    end

    // Clear command uses the long wait, an ordinary command the short one
    push(1'b0, 8'h01, CLR, 1);
    wait_idle(200);
    push(1'b0, 8'h80, EXEC, 1);
    wait_idle(200);

    // Burst of six: first popped immediately, four fill the FIFO, sixth dropped
    for (int i = 0; i < 6; i++) begin
      push(1'b1, 8'(8'h10 + i), EXEC, i < 5);
      if (i == 4) begin
        check("burst_full", int'(o_full), 1);
        check("burst_ovf_before_drop", int'(o_ovf), 0);
      end
      if (i == 5) begin
        check("burst_ovf_after_drop", int'(o_ovf), 1);
        check("burst_full_after_drop", int'(o_full), 1);
      end
    end
    i_ovf_clr = 1'b1;
    @(negedge i_clk);
    i_ovf_clr = 1'b0;
    check("ovf_cleared", int'(o_ovf), 0);
    wait_idle(500);
    check("empty_after_burst", int'(o_empty), 1);

    // Drop and clear in the same cycle: the set wins
    for (int i = 0; i < 6; i++) begin
      if (i == 5) i_ovf_clr = 1'b1;
      push(1'b0, 8'(8'h20 + i), EXEC, i < 5);
      i_ovf_clr = 1'b0;
    end
    check("ovf_set_beats_clr", int'(o_ovf), 1);
    i_ovf_clr = 1'b1;
    @(negedge i_clk);
    i_ovf_clr = 1'b0;
    check("ovf_cleared_again", int'(o_ovf), 0);
    wait_idle(500);

    // Asynchronous reset in the middle of the EN pulse
    push(1'b1, 8'h55, EXEC, 1);
    push(1'b1, 8'h66, EXEC, 0);
    for (int i = 0; i < 20 && !o_lcd_en; i++) @(negedge i_clk);
    check("en_reached", int'(o_lcd_en), 1);
    check("fifo_holds_second", int'(o_empty), 0);
    #2 i_rst = 1'b0;
    #1;
    check("async_rst_en", int'(o_lcd_en), 0);
    check("async_rst_empty", int'(o_empty), 1);
    check("async_rst_busy", int'(o_busy), 0);
    check("async_rst_data", int'(o_lcd_data), 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    check("post_rst_busy", int'(o_busy), 0);
    check("post_rst_en", int'(o_lcd_en), 0);
    push(1'b1, 8'h77, EXEC, 1);
    @(negedge i_clk);
    check("post_rst_pop", int'(o_lcd_data), 8'h77);
    wait_idle(200);

    repeat (5) @(negedge i_clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Downstream consumer of the LSU LCD output register.
- Converts single-cycle LSU stores, one command or data byte per store, into HD44780 write cycles on the DE2 character LCD: setup, EN pulse, hold, then an execution wait.
- A store completes in one cycle and the LSU cannot stall, so requests go into a small FIFO. Requests that arrive while the FIFO is full are dropped and flagged.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries (power of 2, ≥2)
- SETUP_CYC, 2, cycles RS/DATA stable before EN rises (≥1)
- EN_HIGH_CYC, 12, cycles EN held high (≥1)
- HOLD_CYC, 2, cycles RS/DATA held after EN falls (≥1)
- EXEC_CYC, 2000, post-write busy wait for normal commands and data (≥1)
- CLR_CYC, 82000, post-write busy wait for clear/home commands (≥1)
- PWRUP_CYC, 750000, power-on wait before the init sequence (used only with LCD_INIT_EN)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- i_wr_en  in  1  push request (one-cycle pulse from LSU store decode)
- i_wr_rs  in  1  0 = command, 1 = data
- i_wr_data  in  8  byte to write
- i_lcd_on  in  1  backlight/power request
- i_ovf_clr  in  1  clears o_ovf
- o_full  out  1  FIFO full
- o_empty  out  1  FIFO empty
- o_busy  out  1  FSM not IDLE, or FIFO non-empty
- o_ovf  out  1  sticky; a push was dropped
- o_lcd_data  out  8  LCD_DATA
- o_lcd_rs  out  1  LCD_RS
- o_lcd_rw  out  1  LCD_RW (always 0, write-only)
- o_lcd_en  out  1  LCD_EN
- o_lcd_on  out  1  LCD_ON

Behaviour:
- Reset (i_rst=0, asynchronous): FIFO flushed; FSM to IDLE (INIT_WAIT with LCD_INIT_EN); all counters 0.
- Output reset values: o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0, o_full=0, o_empty=1, o_busy=0, o_ovf=0.
- Reset mid-pulse: EN drops to 0 immediately; the pending transfer is lost.
- o_lcd_on: i_lcd_on registered once (1-cycle latency), independent of the FSM.
- Push: on an edge with i_wr_en=1 and o_full=0, {rs,data} is written at the write pointer.
- Push when o_full=1: entry dropped, o_ovf←1. This applies even if a pop happens the same cycle, because fullness is judged on the pre-edge count.
- o_ovf: held until i_ovf_clr=1. If a drop and i_ovf_clr occur in the same cycle, the set wins.
- Pointers are log2(FIFO_DEPTH)+1 bits with wrap bit. Empty = pointers equal; full = MSBs differ, rest equal. Simultaneous push and pop with count in 1..DEPTH-1 leaves count unchanged.
- FSM states: IDLE, SETUP, EN_HI, HOLD, EXEC.
- IDLE: if !o_empty, pop the head, load o_lcd_rs/o_lcd_data, cnt←SETUP_CYC-1, go to SETUP.
- SETUP: count to 0, then EN←1, cnt←EN_HIGH_CYC-1, go to EN_HI.
- EN_HI: count to 0, then EN←0, cnt←HOLD_CYC-1, go to HOLD.
- HOLD: count to 0, then go to EXEC. cnt←CLR_CYC-1 if rs=0 and data∈{0x01,0x02,0x03}, else EXEC_CYC-1.
- EXEC: count to 0, then go to IDLE. o_lcd_data/o_lcd_rs keep their last value until the next pop.
- Latency: push at edge T → pop and data driven at T+1 → EN rises at T+1+SETUP_CYC → EN high exactly EN_HIGH_CYC cycles.
- Back-to-back entry period = SETUP+EN_HIGH+HOLD+EXEC cycles, plus 1 IDLE cycle.
- Counter width = $clog2 of the largest cycle parameter, +1.

Optional Feature:
- Macro: LCD_INIT_EN.
- Defined: after reset, states INIT_WAIT then INIT_SEQ run before IDLE.
  - INIT_WAIT: wait PWRUP_CYC cycles.
  - INIT_SEQ: issue commands 0x38, 0x0C, 0x01, 0x06 through the normal SETUP/EN_HI/HOLD/EXEC path, with 0x01 using CLR_CYC.
  - During init: pushes are still buffered, the FIFO is not popped, and o_busy=1.
- Undefined: starts in IDLE; software must perform init itself.

Test Plan:
Parameters for the bench: SETUP=2, EN_HIGH=3, HOLD=1, EXEC=10, CLR=40, DEPTH=4, no LCD_INIT_EN.
- Reset, then push rs=1 data=0x41 at T → o_lcd_data=0x41 and o_lcd_rs=1 from T+1; o_lcd_en=1 during T+3..T+5; o_busy falls at T+17.
- Push cmd 0x01 → EXEC lasts 40 cycles. Push cmd 0x80 → EXEC lasts 10 cycles.
- 6 pushes on consecutive cycles with data 0x10..0x15:
  - 0x10 is popped at once; 0x11..0x14 fill the FIFO, o_full=1; 0x15 is dropped, o_ovf=1.
  - The LCD receives 0x10..0x14 in order.
  - Pulse i_ovf_clr → o_ovf=0.
- Drop and i_ovf_clr in the same cycle → o_ovf=1.
- Assert i_rst=0 during EN_HI → o_lcd_en=0 immediately with no clock; o_empty=1; after release the FSM is in IDLE.
- i_lcd_on 0→1 → o_lcd_on=1 one cycle later. o_lcd_rw=0 throughout every test.
